// File: rtl/axi_split_pkg.sv
// Shared encodings for the AXI boundary burst splitter: burst types,
// default split boundary and FSM states.
package axi_split_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int DEFAULT_BOUNDARY_BITS = 12;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

endpackage

// File: rtl/axi_split_piece_calc.sv
// Combinational piece sizing: how many beats of the remaining burst fit
// before the next 2^BOUNDARY_BITS boundary, and where the next piece starts.
module axi_split_piece_calc
  import axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int BOUNDARY_BITS = DEFAULT_BOUNDARY_BITS
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [LEN_WIDTH:0]    rem_beats,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [1:0]            burst,
  output logic [LEN_WIDTH-1:0]  piece_len,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int CW   = (BOUNDARY_BITS + 1 > LEN_WIDTH + 1) ? BOUNDARY_BITS + 1 : LEN_WIDTH + 1;
  localparam int HI_W = ADDR_WIDTH - BOUNDARY_BITS;

  logic [BOUNDARY_BITS:0]   off;
  logic [BOUNDARY_BITS:0]   span;
  logic [BOUNDARY_BITS:0]   to_bnd;
  logic [CW-1:0]            rem_ext;
  logic [CW-1:0]            piece;
  logic [HI_W-1:0]          hi_next;

  always_comb begin
    off     = {1'b0, cur_addr[BOUNDARY_BITS-1:0]} >> size;
    span    = ((BOUNDARY_BITS+1)'(1) << BOUNDARY_BITS) >> size;
    // off < span always, so to_bnd is at least one beat
    to_bnd  = span - off;
    rem_ext = CW'(rem_beats);
    if (burst != BURST_INCR) begin
      piece = rem_ext;
    end else if (rem_ext <= CW'(to_bnd)) begin
      piece = rem_ext;
    end else begin
      piece = CW'(to_bnd);
    end
    piece_len = LEN_WIDTH'(piece - CW'(1));
    last      = (piece == rem_ext);
    hi_next   = cur_addr[ADDR_WIDTH-1:BOUNDARY_BITS] + HI_W'(1);
    next_addr = {hi_next, {BOUNDARY_BITS{1'b0}}};
  end

endmodule

// File: rtl/axi_boundary_burst_splitter.sv
// Splits one AXI4 AW/AR request into pieces that never cross a
// 2^BOUNDARY_BITS-byte boundary and issues them back-to-back in order.
module axi_boundary_burst_splitter
  import axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int ID_WIDTH      = 5,
  parameter int BOUNDARY_BITS = DEFAULT_BOUNDARY_BITS,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   s_AxID_i,
  input  logic [ADDR_WIDTH-1:0] s_AxADDR_i,
  input  logic [LEN_WIDTH-1:0]  s_AxLEN_i,
  input  logic [SIZE_WIDTH-1:0] s_AxSIZE_i,
  input  logic [1:0]            s_AxBURST_i,
  input  logic                  s_AxVALID_i,
  output logic                  s_AxREADY_o,
  output logic [ID_WIDTH-1:0]   m_AxID_o,
  output logic [ADDR_WIDTH-1:0] m_AxADDR_o,
  output logic [LEN_WIDTH-1:0]  m_AxLEN_o,
  output logic [SIZE_WIDTH-1:0] m_AxSIZE_o,
  output logic [1:0]            m_AxBURST_o,
  output logic                  m_AxVALID_o,
  input  logic                  m_AxREADY_i,
  output logic                  m_last_piece_o,
  output logic [CNT_WIDTH-1:0]  m_piece_idx_o
);

  state_e                state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  last_q, last_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH:0]    rem_q, rem_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  load;

  logic [LEN_WIDTH-1:0]  calc_len;
  logic                  calc_last;
  logic [ADDR_WIDTH-1:0] calc_next;

  // The calculator looks at the next-state address/remainder so that the
  // piece fields can be registered together with the address.
  axi_split_piece_calc #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .SIZE_WIDTH   (SIZE_WIDTH),
    .BOUNDARY_BITS(BOUNDARY_BITS)
  ) u_calc (
    .cur_addr (addr_d),
    .rem_beats(rem_d),
    .size     (size_d),
    .burst    (burst_d),
    .piece_len(calc_len),
    .last     (calc_last),
    .next_addr(calc_next)
  );

  always_comb begin
    state_d   = state_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    size_d    = size_q;
    burst_d   = burst_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_AxVALID_i && s_ready_q) begin
          state_d   = SPLIT;
          s_ready_d = 1'b0;
          m_valid_d = 1'b1;
          idx_d     = '0;
          addr_d    = s_AxADDR_i;
          rem_d     = {1'b0, s_AxLEN_i} + (LEN_WIDTH+1)'(1);
          id_d      = s_AxID_i;
          size_d    = s_AxSIZE_i;
          burst_d   = s_AxBURST_i;
          load      = 1'b1;
        end else begin
          s_ready_d = 1'b1;
        end
      end
      SPLIT: begin
        if (m_valid_q && m_AxREADY_i) begin
          if (last_q) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
            idx_d     = '0;
          end else begin
            addr_d = nxt_q;
            rem_d  = rem_q - ({1'b0, len_q} + (LEN_WIDTH+1)'(1));
            idx_d  = (idx_q == {CNT_WIDTH{1'b1}}) ? idx_q : idx_q + CNT_WIDTH'(1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d  = len_q;
    last_d = last_q;
    nxt_d  = nxt_q;
    if (load) begin
      len_d  = calc_len;
      last_d = calc_last;
      nxt_d  = calc_next;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      nxt_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      id_q      <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      nxt_q     <= nxt_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
    end
  end

  assign s_AxREADY_o    = s_ready_q;
  assign m_AxVALID_o    = m_valid_q;
  assign m_AxID_o       = id_q;
  assign m_AxADDR_o     = addr_q;
  assign m_AxLEN_o      = len_q;
  assign m_AxSIZE_o     = size_q;
  assign m_AxBURST_o    = burst_q;
  assign m_last_piece_o = last_q;
  assign m_piece_idx_o  = idx_q;

endmodule

// File: doc/axi_boundary_burst_splitter.md
Name: axi_boundary_burst_splitter

Overview:
Registered AxADDR/AxLEN splitter for one AXI4 AW or AR channel. It divides an INCR burst at every 2^BOUNDARY_BITS-byte boundary, not just the first, and emits the pieces in order over a valid/ready handshake. A last-piece flag and a piece count go to the response merger. It sits between the slave-side arbiter output and the master-side address decoder, one instance per AW/AR path.

Parameters:
ADDR_WIDTH, 32, address width
LEN_WIDTH, 8, AxLEN width (AXI4 = 8)
SIZE_WIDTH, 3, AxSIZE width
ID_WIDTH, 5, AxID width
BOUNDARY_BITS, 12, log2 of split boundary in bytes (12 = 4KB)
CNT_WIDTH, 4, width of piece counter

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
s_AxID_i  in  ID_WIDTH  incoming ID
s_AxADDR_i  in  ADDR_WIDTH  incoming start address
s_AxLEN_i  in  LEN_WIDTH  incoming beats-1
s_AxSIZE_i  in  SIZE_WIDTH  incoming beat size (log2 bytes)
s_AxBURST_i  in  2  incoming burst type
s_AxVALID_i  in  1  request valid
s_AxREADY_o  out  1  request accepted
m_AxID_o  out  ID_WIDTH  piece ID (= input ID)
m_AxADDR_o  out  ADDR_WIDTH  piece start address
m_AxLEN_o  out  LEN_WIDTH  piece beats-1
m_AxSIZE_o  out  SIZE_WIDTH  piece size (= input size)
m_AxBURST_o  out  2  piece burst (= input burst)
m_AxVALID_o  out  1  piece valid
m_AxREADY_i  in  1  piece accepted
m_last_piece_o  out  1  high with the final piece of a request
m_piece_idx_o  out  CNT_WIDTH  0-based index of current piece

Behaviour:
- FSM states: IDLE and SPLIT. Reset (async, ARESETn low) sets state=IDLE, s_AxREADY_o=0, m_AxVALID_o=0, m_last_piece_o=0, m_piece_idx_o=0, m_AxADDR_o=0, m_AxLEN_o=0, and ID/SIZE/BURST outputs=0.
- s_AxREADY_o is registered. It is 1 only in IDLE, starting the first ACLK edge after reset release.
- IDLE: on s_AxVALID_i&&s_AxREADY_o, capture ID/ADDR/SIZE/BURST and rem_beats=LEN+1 (LEN_WIDTH+1 bits). Go to SPLIT and drop s_AxREADY_o. m_AxVALID_o rises the next cycle (1-cycle latency).
- Piece computation is combinational from registered cur_addr/rem_beats:
  - off = cur_addr[BOUNDARY_BITS-1:0] >> size, evaluated in BOUNDARY_BITS+1 bits.
  - to_bnd = (2^BOUNDARY_BITS >> size) - off, never zero.
  - piece = min(rem_beats, to_bnd). m_AxLEN_o = piece-1. m_last_piece_o = (piece==rem_beats).
- The first piece keeps the original, possibly unaligned, address. Later pieces use {cur_addr[ADDR_WIDTH-1:BOUNDARY_BITS]+1, zeros}.
- BURST != INCR (FIXED, WRAP): a single piece with the original LEN, last=1, idx=0. No split.
- SPLIT, on m_AxVALID_o&&m_AxREADY_i:
  - if last: return to IDLE, clear m_AxVALID_o, raise s_AxREADY_o, reset idx to 0 in the same edge;
  - else: rem_beats -= piece, cur_addr advances to the next boundary, idx++, and m_AxVALID_o stays 1 (next piece the following cycle, no bubble).
- While m_AxVALID_o=1 and m_AxREADY_i=0, all m_* outputs hold stable (AXI rule).
- Maximum pieces = 2^(LEN_WIDTH+SIZE_MAX)/2^BOUNDARY_BITS+1. This is 9 for the defaults, and CNT_WIDTH must hold it. idx saturates at 2^CNT_WIDTH-1.
- Throughput: one request per (pieces+1) cycles minimum.
- ARESETn asserted mid-SPLIT aborts the request immediately. No pieces are emitted after release.
- Address increment wrapping past the top of the address space wraps modulo 2^ADDR_WIDTH. No flag is raised.

Decomposition:
- Shared package axi_split_pkg:
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - DEFAULT_BOUNDARY_BITS=12;
  - FSM state encodings IDLE/SPLIT.
- One sub-module: axi_split_piece_calc. It is combinational, takes (cur_addr, rem_beats, size, burst) and returns (piece_len, last, next_addr). This lets it be unit-tested alone.

Test Plan:
- ADDR=0x0000_0100, LEN=15, SIZE=2, INCR -> one piece ADDR 0x100 LEN 15, last=1, idx=0; s_AxREADY_o back high 1 cycle after handshake.
- ADDR=0x0000_0FF0, LEN=7, SIZE=2 -> two pieces:
  - piece 0: 0xFF0 LEN 3, last=0, idx=0;
  - piece 1: 0x1000 LEN 3, last=1, idx=1.
- ADDR=0x0000_0F80, LEN=255, SIZE=7 -> 9 pieces:
  - 0xF80 LEN 0;
  - 0x1000..0x7000 LEN 31 each;
  - 0x8000 LEN 30 last=1.
  - Sum of beats = 256.
- Unaligned ADDR=0x0000_0FFE, LEN=1, SIZE=2 -> two pieces:
  - piece 0: 0xFFE LEN 0;
  - piece 1: 0x1000 LEN 0 last=1.
- WRAP, ADDR=0x0000_0FF0, LEN=3, SIZE=2 -> single piece, unchanged fields, last=1.
- Back-pressure and reset:
  - hold m_AxREADY_i=0 for 5 cycles on piece 0 of the 2-piece case -> outputs stable;
  - assert ARESETn low during piece 1 -> m_AxVALID_o=0 and s_AxREADY_o=0 immediately, state IDLE after release.
